// File: rtl/project1.sv
// Iterative x/u/y stepper: IDLE -> CHECK <-> UPDATE -> DONE, all arithmetic modulo 256.
// Optional iteration-limit abort guarded by `PROJECT1_ITER_LIMIT_EN (err tied 0 when undefined).
module project1 #(
    parameter logic [7:0] DX = 8'd1,
    parameter logic [7:0] A  = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [7:0] u_in,
    input  logic [7:0] y_in,
    output logic [7:0] x_out,
    output logic [7:0] u_out,
    output logic [7:0] y_out,
    output logic       done,
    output logic       err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic [7:0] xr, ur, yr;
    logic       at_limit;

`ifdef PROJECT1_ITER_LIMIT_EN
    logic [7:0] cnt;
    logic       err_q;

    assign at_limit = (cnt == 8'hFF);
    assign err      = err_q;
`else
    assign at_limit = 1'b0;
    assign err      = 1'b0;
`endif

    // All operands are 8 bits wide, so every product and sum wraps modulo 256.
    logic [7:0] u_next, y_next, x_next;
    assign x_next = xr + DX;
    assign u_next = ur - 8'd3 * xr * ur * DX - 8'd3 * yr * DX;
    assign y_next = yr + ur * DX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            xr    <= '0;
            ur    <= '0;
            yr    <= '0;
            x_out <= '0;
            u_out <= '0;
            y_out <= '0;
            done  <= 1'b0;
`ifdef PROJECT1_ITER_LIMIT_EN
            cnt   <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PROJECT1_ITER_LIMIT_EN
            err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x_in;
                        ur    <= u_in;
                        yr    <= y_in;
`ifdef PROJECT1_ITER_LIMIT_EN
                        cnt   <= '0;
`endif
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (at_limit || !(xr < A)) begin
                        x_out <= xr;
                        u_out <= ur;
                        y_out <= yr;
                        done  <= 1'b1;
`ifdef PROJECT1_ITER_LIMIT_EN
                        err_q <= at_limit;
`endif
                        state <= DONE;
                    end else begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    xr    <= x_next;
                    ur    <= u_next;
                    yr    <= y_next;
`ifdef PROJECT1_ITER_LIMIT_EN
                    cnt   <= cnt + 8'd1;
`endif
                    state <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_project1.sv
// Scoreboard bench for project1: drivers push expected results, a negedge monitor pops on done.
module tb_project1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] x_in, u_in, y_in;
    logic [7:0] x_out, u_out, y_out;
    logic       done, err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] x, u, y;
        logic       e;
        int         due;
    } exp_t;
    exp_t q[$];

    project1 dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in(x_in), .u_in(u_in), .y_in(y_in),
        .x_out(x_out), .u_out(u_out), .y_out(y_out),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("x_out", x_out, e.x);
                chk("u_out", u_out, e.u);
                chk("y_out", y_out, e.y);
                chk("err",   err,   e.e);
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic push(input logic [7:0] x, u, y, input int lat, input int c0);
        exp_t e;
        e.x = x; e.u = u; e.y = y; e.e = 1'b0; e.due = c0 + lat;
        q.push_back(e);
    endtask

    // Issues one start pulse; returns the cycle stamp of the sampling edge.
    task automatic kick(input logic [7:0] x, u, y, output int c0);
        @(negedge clk);
        x_in = x; u_in = u; y_in = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 0, 1);
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    int c0;

    initial begin
        rst = 1'b1; start = 1'b0; x_in = '0; u_in = '0; y_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_x_out", x_out, 0);
        chk("rst_u_out", u_out, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_done",  done,  0);
        chk("rst_err",   err,   0);

        // Two iterations with wrap: (2,4,4) -> (4,232,232)
        kick(8'd2, 8'd4, 8'd4, c0);
        push(8'd4, 8'd232, 8'd232, 5, c0);
        drain();

        // x already >= A: zero iterations
        kick(8'd9, 8'd7, 8'd3, c0);
        push(8'd9, 8'd7, 8'd3, 1, c0);
        drain();

        // One iteration: (3,1,0) -> (4,248,1)
        kick(8'd3, 8'd1, 8'd0, c0);
        push(8'd4, 8'd248, 8'd1, 3, c0);
        drain();

        // Four iterations, y wraps to 0: (0,10,20) -> (4,206,0)
        kick(8'd0, 8'd10, 8'd20, c0);
        push(8'd4, 8'd206, 8'd0, 9, c0);
        drain();

        // Start re-pulsed and inputs changed mid-run: ignored, one done only
        kick(8'd2, 8'd4, 8'd4, c0);
        push(8'd4, 8'd232, 8'd232, 5, c0);
        @(negedge clk);
        start = 1'b1; x_in = 8'd9; u_in = 8'd1; y_in = 8'd1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start held high: second run begins right after DONE returns to IDLE
        @(negedge clk);
        x_in = 8'd9; u_in = 8'd7; y_in = 8'd3; start = 1'b1;
        @(negedge clk);
        c0 = cyc;
        push(8'd9, 8'd7, 8'd3, 1, c0);
        x_in = 8'd5; u_in = 8'd1; y_in = 8'd2;
        repeat (3) @(negedge clk);
        start = 1'b0;
        push(8'd5, 8'd1, 8'd2, 4, c0);
        drain();

        // Reset mid-run: outputs cleared, aborted run yields no done
        kick(8'd2, 8'd4, 8'd4, c0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_x_out", x_out, 0);
        chk("midrst_u_out", u_out, 0);
        chk("midrst_y_out", y_out, 0);
        chk("midrst_done",  done,  0);
        repeat (10) @(negedge clk);
        chk("midrst_hold_u", u_out, 0);
        kick(8'd2, 8'd4, 8'd4, c0);
        push(8'd4, 8'd232, 8'd232, 5, c0);
        drain();

`ifdef PROJECT1_ITER_LIMIT_EN
        lim_test();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

`ifdef PROJECT1_ITER_LIMIT_EN
    logic       start_l;
    logic [7:0] x_out_l, u_out_l, y_out_l;
    logic       done_l, err_l;

    project1 #(.DX(8'd0)) dut_lim (
        .clk(clk), .rst(rst), .start(start_l),
        .x_in(8'd0), .u_in(8'd0), .y_in(8'd0),
        .x_out(x_out_l), .u_out(u_out_l), .y_out(y_out_l),
        .done(done_l), .err(err_l)
    );

    initial start_l = 1'b0;

    // DX=0 never advances x, so only the 255-iteration limit ends the run.
    task automatic lim_test();
        int s, n;
        @(negedge clk);
        start_l = 1'b1;
        @(negedge clk);
        start_l = 1'b0;
        s = cyc;
        n = 0;
        while (!done_l && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("lim_done_seen", done_l, 1);
        chk("lim_latency", cyc - s, 511);
        chk("lim_err", err_l, 1);
        chk("lim_x_out", x_out_l, 0);
        @(negedge clk);
        chk("lim_err_clear", err_l, 0);
    endtask
`endif

endmodule
